muldiv_seq: RTL and testbench

Iterative multiply/divide unit implementing the RISC-V M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the 64-bit datapath.
- Parametrised successor to the combinational ALU: generalised to any XLEN and adds multi-cycle operation with a start/busy/done handshake.
- Sits beside ALU_64bit in EX; the control unit stalls the pipeline while busy=1.
- Uses one radix-2 shift-add/restoring-subtract datapath: one bit per cycle.

---
 rtl/muldiv_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq -- iterative RISC-V M-extension multiply/divide unit.
//
// Radix-2 datapath, one bit per cycle: shift-add for MUL/MULH/MULHSU/MULHU,
// restoring subtract for DIV/DIVU/REM/REMU. Operands are reduced to unsigned
// magnitudes in SETUP and the sign is re-applied in FINISH.
// Flow: IDLE -> SETUP -> RUN (XLEN cycles) -> FINISH -> IDLE.
//
// Parameters:
//   XLEN       operand/result width (>= 8)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset (aborts any operation)
//   start      request, accepted only in IDLE with busy=0
//   op[2:0]    funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   A, B       rs1 / rs2 operands, latched on accept
//   busy       high from the cycle after accept through the done cycle
//   done       one-cycle pulse, Result valid
//   Result     result, held until overwritten by the next completion
//   DivByZero  divide op with B=0, updated together with Result
//
// Build option:
//   MULDIV_EARLY_TERM_EN  multiplies leave RUN once the remaining multiplier
//                         is zero; results are identical, only latency drops.
// ---------------------------------------------------------------------------
module muldiv_seq #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] Result,
   output logic            DivByZero
);

   localparam int CW = $clog2(XLEN + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_RUN    = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]     CNT_INIT = CW'(XLEN);
   localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        r_state;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_a;
   logic [XLEN-1:0]   r_b;
   logic [XLEN-1:0]   r_mag_a;      // multiplicand magnitude
   logic [XLEN-1:0]   r_mag_b;      // multiplier (shifts right) or divisor
   logic [2*XLEN-1:0] r_acc;        // product, or {remainder, quotient}
   logic [CW-1:0]     r_cnt;
   logic              r_neg_q;      // negate product / quotient
   logic              r_neg_r;      // negate remainder
   logic              r_dbz_pend;
   logic              r_busy;
   logic              r_done;
   logic [XLEN-1:0]   r_result;
   logic              r_dbz;

   // ---------------- operand decode (from latched op) ----------------
   logic            w_is_div;
   logic            w_sgn_a;
   logic            w_sgn_b;
   logic            w_sa;
   logic            w_sb;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic            w_b_zero;
   logic            w_ovf;

   assign w_is_div = r_op[2];
   assign w_sgn_a  = (r_op == 3'b001) || (r_op == 3'b010) ||
                     (r_op == 3'b100) || (r_op == 3'b110);
   assign w_sgn_b  = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
   assign w_sa     = w_sgn_a & r_a[XLEN-1];
   assign w_sb     = w_sgn_b & r_b[XLEN-1];
   // The most negative value maps onto itself, which is the correct
   // unsigned magnitude 2^(XLEN-1).
   assign w_abs_a  = w_sa ? (~r_a + ONE_X) : r_a;
   assign w_abs_b  = w_sb ? (~r_b + ONE_X) : r_b;
   assign w_b_zero = (r_b == '0);
   assign w_ovf    = w_is_div & w_sgn_b & (r_a == MIN_NEG) & (&r_b);

   // ---------------- multiply step ----------------
   logic [XLEN:0]     w_addend;
   logic [XLEN:0]     w_sum;
   logic [2*XLEN-1:0] w_mul_next;
   logic [XLEN-1:0]   w_b_shr;
   logic              w_mul_stop;

   assign w_addend   = r_mag_b[0] ? {1'b0, r_mag_a} : '0;
   // Carry out of the upper half shifts straight back into the accumulator.
   assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + w_addend;
   assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};
   assign w_b_shr    = r_mag_b >> 1;

`ifdef MULDIV_EARLY_TERM_EN
   assign w_mul_stop = (w_b_shr == '0);
`else
   assign w_mul_stop = 1'b0;
`endif

   // ---------------- divide step ----------------
   logic [XLEN:0]     w_shl;        // remainder shifted left with next dividend bit
   logic [XLEN+1:0]   w_trial;
   logic              w_trial_neg;
   logic [2*XLEN-1:0] w_div_next;

   assign w_shl       = r_acc[2*XLEN-1:XLEN-1];
   assign w_trial     = {1'b0, w_shl} - {2'b00, r_mag_b};
   assign w_trial_neg = w_trial[XLEN+1];
   assign w_div_next  = w_trial_neg ? {w_shl[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                    : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

   // w_trial[XLEN] is always zero when the trial succeeds (rem < divisor).
   logic w_unused;
   assign w_unused = w_trial[XLEN];

   // ---------------- result formation ----------------
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_quo_s;
   logic [XLEN-1:0]   w_rem_s;
   logic [XLEN-1:0]   w_sel;

`ifdef MULDIV_EARLY_TERM_EN
   // An early exit leaves the product short by r_cnt right shifts.
   assign w_prod = r_acc >> r_cnt;
`else
   assign w_prod = r_acc;
`endif

   assign w_prod_s = r_neg_q ? (~w_prod + ONE_2X) : w_prod;
   assign w_quo_s  = r_neg_q ? (~r_acc[XLEN-1:0] + ONE_X) : r_acc[XLEN-1:0];
   assign w_rem_s  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + ONE_X)
                             : r_acc[2*XLEN-1:XLEN];

   always_comb begin
      w_sel = '0;
      case (r_op)
         3'b000:                 w_sel = w_prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_sel = w_prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_sel = w_quo_s;
         default:                w_sel = w_rem_s;
      endcase
   end

   // ---------------- control ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_mag_a    <= '0;
         r_mag_b    <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dbz_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
         r_dbz      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // busy still set here means this is the done cycle: drop busy
               // and ignore start for one cycle.
               if (r_busy) begin
                  r_busy <= 1'b0;
               end else if (start) begin
                  r_op    <= op;
                  r_a     <= A;
                  r_b     <= B;
                  r_busy  <= 1'b1;
                  r_state <= S_SETUP;
               end
            end

            S_SETUP: begin
               r_mag_a    <= w_abs_a;
               r_mag_b    <= w_abs_b;
               r_cnt      <= CNT_INIT;
               r_neg_q    <= w_sa ^ w_sb;
               r_neg_r    <= w_sa;
               r_dbz_pend <= 1'b0;
               r_acc      <= w_is_div ? {{XLEN{1'b0}}, w_abs_a} : '0;
               r_state    <= S_RUN;
               if (w_is_div && w_b_zero) begin
                  // {remainder, quotient} = {A, all ones}, no sign fix-up
                  r_acc      <= {r_a, {XLEN{1'b1}}};
                  r_neg_q    <= 1'b0;
                  r_neg_r    <= 1'b0;
                  r_dbz_pend <= 1'b1;
                  r_state    <= S_FINISH;
               end else if (w_ovf) begin
                  // {remainder, quotient} = {0, A}
                  r_acc   <= {{XLEN{1'b0}}, r_a};
                  r_neg_q <= 1'b0;
                  r_neg_r <= 1'b0;
                  r_state <= S_FINISH;
               end
            end

            S_RUN: begin
               r_cnt <= r_cnt - CNT_ONE;
               if (w_is_div) begin
                  r_acc <= w_div_next;
                  if (r_cnt == CNT_ONE) r_state <= S_FINISH;
               end else begin
                  r_acc   <= w_mul_next;
                  r_mag_b <= w_b_shr;
                  if ((r_cnt == CNT_ONE) || w_mul_stop) r_state <= S_FINISH;
               end
            end

            S_FINISH: begin
               r_result <= w_sel;
               r_dbz    <= r_dbz_pend;
               r_done   <= 1'b1;
               r_state  <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign Result    = r_result;
   assign DivByZero = r_dbz;

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq -- scoreboard bench for muldiv_seq (XLEN=64).
// The driver pushes the reference-model answer and its accept cycle into a
// queue; an independent monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

   localparam int XLEN = 64;
   localparam logic [63:0] MINV = {1'b1, 63'b0};
   localparam logic [63:0] ONES = {64{1'b1}};

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [63:0] A;
   logic [63:0] B;
   logic        busy;
   logic        done;
   logic [63:0] Result;
   logic        DivByZero;

   muldiv_seq #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done), .Result(Result), .DivByZero(DivByZero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] res;
      logic        dbz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain wide arithmetic on the RISC-V definitions.
   function automatic void model(input logic [2:0] o, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] r,
                                 output logic d, output int lat);
      logic [127:0] ae, be, p;
      logic         sgn;
      d   = 1'b0;
      lat = XLEN + 2;
      r   = '0;
      if (!o[2]) begin
         ae = (o == 3'd1 || o == 3'd2) ? {{64{a[63]}}, a} : {64'b0, a};
         be = (o == 3'd1)              ? {{64{b[63]}}, b} : {64'b0, b};
         p  = ae * be;
         r  = (o == 3'd0) ? p[63:0] : p[127:64];
`ifdef MULDIV_EARLY_TERM_EN
         begin
            logic [63:0] bm;
            int          k;
            bm = (o == 3'd1 && b[63]) ? (64'd0 - b) : b;
            k  = 1;
            for (int i = 0; i < 64; i++) if (bm[i]) k = i + 1;
            lat = k + 2;
         end
`endif
      end else begin
         sgn = (o == 3'd4 || o == 3'd6);
         if (b == 64'd0) begin
            d   = 1'b1;
            r   = o[1] ? a : ONES;
            lat = 2;
         end else if (sgn && a == MINV && b == ONES) begin
            r   = o[1] ? 64'd0 : a;
            lat = 2;
         end else if (sgn) begin
            r = o[1] ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
         end else begin
            r = o[1] ? (a % b) : (a / b);
         end
      end
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (reset === 1'b0 && done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got done=1 want done=0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk64("result", Result, e.res);
            chk64("divbyzero", {63'b0, DivByZero}, {63'b0, e.dbz});
            chki("latency", cyc - e.acc, e.lat);
            chk64("busy_in_done", {63'b0, busy}, 64'd1);
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      int   n;
      n = 0;
      while (busy === 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout got busy=1 want busy=0 (cycle %0d)", cyc);
      end
      op = o; A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model(o, a, b, e.res, e.dbz, e.lat);
      e.acc = cyc;
      sb.push_back(e);
      // scramble inputs: the latched copies must be used
      op = 3'($urandom); A = {$urandom, $urandom}; B = {$urandom, $urandom};
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy === 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got pending=%0d want 0 (cycle %0d)", sb.size(), cyc);
         sb = {};
      end
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return ONES;
         2:       return MINV;
         3:       return 64'($urandom_range(0, 300));
         4:       return 64'(-$signed(32'($urandom_range(1, 300))));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog got timeout want completion (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
      repeat (3) @(negedge clk);
      chk64("reset_busy", {63'b0, busy}, 64'd0);
      chk64("reset_done", {63'b0, done}, 64'd0);
      chk64("reset_result", Result, 64'd0);
      chk64("reset_dbz", {63'b0, DivByZero}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // directed values
      issue(3'd0, 64'(-5), 64'd12);
      issue(3'd1, 64'(-5), 64'd12);
      issue(3'd3, ONES, ONES);
      issue(3'd2, ONES, ONES);
      issue(3'd4, 64'(-20), 64'd6);
      issue(3'd6, 64'(-20), 64'd6);
      issue(3'd5, 64'd111, 64'd20);
      issue(3'd7, 64'd111, 64'd20);
      issue(3'd4, 64'd123, 64'd0);
      issue(3'd6, 64'd123, 64'd0);
      issue(3'd5, 64'd9, 64'd0);
      issue(3'd4, MINV, ONES);
      issue(3'd6, MINV, ONES);
      issue(3'd1, MINV, MINV);
      issue(3'd0, 64'd7, 64'd1);
      drain();

      // start during an operation is ignored
      issue(3'd0, 64'd1234, 64'd5678);
      repeat (9) @(negedge clk);
      op = 3'd4; A = 64'd99; B = 64'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // start during the done cycle is ignored
      issue(3'd5, 64'd1000, 64'd7);
      begin
         int n;
         n = 0;
         while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
         end
         chki("done_seen", (done === 1'b1) ? 1 : 0, 1);
      end
      op = 3'd0; A = 64'd3; B = 64'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk64("start_in_done_ignored", {63'b0, busy}, 64'd0);
      repeat (4) @(negedge clk);

      // reset mid-operation aborts with no done
      issue(3'd1, {$urandom, $urandom}, {$urandom, $urandom});
      repeat (29) @(negedge clk);
      reset = 1'b1;
      sb = {};
      @(negedge clk);
      reset = 1'b0;
      chk64("abort_busy", {63'b0, busy}, 64'd0);
      chk64("abort_result", Result, 64'd0);
      chk64("abort_done", {63'b0, done}, 64'd0);
      repeat (80) @(negedge clk);
      issue(3'd0, 64'(-5), 64'd12);
      drain();

      // randomized
      for (int i = 0; i < 50; i++) begin
         issue(3'($urandom_range(0, 7)), pick(), pick());
      end
      drain();

      chki("queue_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
